mac_psum_accum: RTL and testbench
=================================

Name: mac_psum_accum

Overview:
- Sits directly downstream of the 4-lane `mac` datapath and closes its accumulation loop.
- Accepts one group of 4 activation/weight nibble pairs per handshake and drives them to `mac`.
- Feeds the running partial sum back into `mac`'s `c` input and registers `mac`'s `out` as the new partial sum.
- After `k_groups` groups it presents the final partial sum on a valid/ready output port, with optional ReLU.

Parameters:
- bw, 4, activation/weight element width (4 lanes per group)
- psum_bw, 16, partial-sum width; matches `mac` `psum_bw`
- cnt_bw, 8, width of the group-length input and the internal group counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  a group is present on a_in/b_in
- in_ready  output  1  block accepts a group this cycle
- a_in  input  4*bw  4 unsigned activations, lane i at [bw*(i+1)-1 : bw*i]
- b_in  input  4*bw  4 signed weights, same lane packing
- k_groups  input  cnt_bw  groups per result; sampled on the first beat of each result
- relu_en  input  1  apply ReLU to the result; sampled on the last beat
- mac_a  output  4*bw  to mac.a
- mac_b  output  4*bw  to mac.b
- mac_c  output  psum_bw  to mac.c (signed running psum)
- mac_out  input  psum_bw  from mac.out (signed)
- out_valid  output  1  psum_out holds a final result
- out_ready  input  1  consumer accepts the result
- psum_out  output  psum_bw  signed final result

Behaviour:
- Timing: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, acc=0, cnt=0, k_lat=0, out_valid=0, psum_out=0. Reset mid-operation discards the partial result and any pending output.
- mac_a=a_in and mac_b=b_in pass through combinationally. mac_c=acc (register, signed). The mac is combinational, so mac_out is valid in the same cycle.
- A beat is accepted when in_valid && in_ready. in_ready must not depend on in_valid.
- States:
  - IDLE: in_ready=1, acc=0. On an accepted beat:
    - Latch k_lat = (k_groups==0 ? 1 : k_groups); zero is treated as 1.
    - acc<=mac_out, cnt<=1.
    - If k_lat==1, go to DONE (see last beat below); otherwise go to ACC.
  - ACC: in_ready=1. On an accepted beat: acc<=mac_out, cnt<=cnt+1. If cnt+1==k_lat, go to DONE. No beat means hold.
  - Last beat (entering DONE):
    - psum_out<=(relu_en && mac_out[psum_bw-1]) ? 0 : mac_out.
    - out_valid<=1, acc<=0, cnt<=0.
  - DONE: in_ready=0 and psum_out is held stable. On out_valid && out_ready: out_valid<=0, go to IDLE. No combinational ready-to-valid path exists.
- Latency: out_valid rises the cycle after the last accepted beat. Minimum period per result is k_lat+1 cycles.
- Arithmetic: accumulation is two's-complement, modulo 2^psum_bw (wraps silently, no saturation). ReLU is applied only to the final value.
- Changes to k_groups or relu_en outside their sampling beats have no effect on the result in progress.

Decomposition:
- Shared package holds:
  - constants BW=4, PSUM_BW=16, CNT_BW=8, LANES=4;
  - typedef psum_t (signed [PSUM_BW-1:0]);
  - enum state_t {IDLE, ACC, DONE}.
- No sub-module is required: `mac` stays a separate instance wired at the parent level.
- The ReLU is a one-line expression and is not split out.

Test Plan:
- The bench instantiates the real `mac` for integration runs. It also instantiates a golden model computing mac_out = mac_c + Σ a_i*b_i for block checks.
- Basic: k=3, every lane a=4'h1, b=4'h2, in_valid held high -> out_valid on cycle 4 with psum_out=16'd24. in_ready=0 exactly while out_valid=1.
- Negative and ReLU: k=2, a=4'h3, b=4'hF:
  - relu_en=0 -> psum_out=16'hFFE8 (-24);
  - relu_en=1 -> psum_out=16'h0000.
- Backpressure and bubbles: k=4 with in_valid toggled 1,0,1,0,1,1 (a=1, b=1) -> psum_out=16'd16. Then out_ready low for 5 cycles -> psum_out/out_valid held and in_ready=0; releases in the cycle out_ready=1.
- Edge lengths: k=0 with a=2, b=3 -> treated as 1, psum_out=16'd24. A back-to-back second result with k=1 returns 24 again, confirming acc cleared between results.
- Wrap: k=160, a=4'hF, b=4'h7 -> 160*420=67200 -> psum_out=16'h0680 (1664).
- Reset mid-operation: k=4, reset asserted for 1 cycle after beat 2 -> out_valid=0, acc=0. A following k=1, a=1, b=1 gives psum_out=16'd4.

Source files
------------

// File: rtl/mac_psum_accum_pkg.sv
// Shared constants, types and FSM states for the mac partial-sum accumulator.
package mac_psum_accum_pkg;

  localparam int unsigned BW      = 4;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned CNT_BW  = 8;
  localparam int unsigned LANES   = 4;

  typedef logic signed [PSUM_BW-1:0] psum_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/mac_psum_accum_if.sv
// Group-input and result-output streams of the accumulator, plus per-result controls.
interface mac_psum_accum_if;
  import mac_psum_accum_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*BW-1:0]   a_in;
  logic [LANES*BW-1:0]   b_in;
  logic [CNT_BW-1:0]     k_groups;
  logic                  relu_en;
  logic                  out_valid;
  logic                  out_ready;
  psum_t                 psum_out;

  modport slave (
    input  in_valid, a_in, b_in, k_groups, relu_en, out_ready,
    output in_ready, out_valid, psum_out
  );

  modport master (
    output in_valid, a_in, b_in, k_groups, relu_en, out_ready,
    input  in_ready, out_valid, psum_out
  );

endinterface

// File: rtl/mac_psum_accum.sv
// Closes the accumulation loop around a combinational 4-lane mac and emits one
// (optionally ReLU'd) partial sum every k_groups accepted groups.
module mac_psum_accum
  import mac_psum_accum_pkg::*;
#(
  parameter int unsigned bw      = BW,
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned cnt_bw  = CNT_BW
) (
  input  logic                      clk,
  input  logic                      reset,
  mac_psum_accum_if.slave           io,
  output logic [LANES*bw-1:0]       mac_a,
  output logic [LANES*bw-1:0]       mac_b,
  output logic signed [psum_bw-1:0] mac_c,
  input  logic signed [psum_bw-1:0] mac_out
);

  state_t                    state, state_nxt;
  logic signed [psum_bw-1:0] acc, acc_nxt;
  logic signed [psum_bw-1:0] psum_q, psum_nxt;
  logic [cnt_bw-1:0]         cnt, cnt_nxt;
  logic [cnt_bw-1:0]         k_lat, k_lat_nxt;
  logic [cnt_bw-1:0]         k_eff;
  logic [cnt_bw-1:0]         cnt_inc;
  logic                      out_valid_q, out_valid_nxt;
  logic                      beat;
  logic                      last;

  // The mac is purely combinational: operands flow straight through.
  assign mac_a = io.a_in;
  assign mac_b = io.b_in;
  assign mac_c = acc;

  // Ready is a pure state decode, never a function of in_valid or out_ready.
  assign io.in_ready  = (state != DONE);
  assign io.out_valid = out_valid_q;
  assign io.psum_out  = psum_q;

  assign beat    = io.in_valid && io.in_ready;
  assign k_eff   = (io.k_groups == '0) ? cnt_bw'(1) : cnt_bw'(io.k_groups);
  assign cnt_inc = cnt + cnt_bw'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      k_lat       <= '0;
      out_valid_q <= 1'b0;
      psum_q      <= '0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      k_lat       <= k_lat_nxt;
      out_valid_q <= out_valid_nxt;
      psum_q      <= psum_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    k_lat_nxt     = k_lat;
    out_valid_nxt = out_valid_q;
    psum_nxt      = psum_q;
    last          = 1'b0;

    case (state)
      IDLE: begin
        if (beat) begin
          k_lat_nxt = k_eff;
          acc_nxt   = mac_out;
          cnt_nxt   = cnt_bw'(1);
          if (k_eff == cnt_bw'(1)) last = 1'b1;
          else                     state_nxt = ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_nxt = mac_out;
          cnt_nxt = cnt_inc;
          if (cnt_inc == k_lat) last = 1'b1;
        end
      end
      DONE: begin
        if (out_valid_q && io.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Final beat: capture result, clear the loop for the next group set.
    if (last) begin
      state_nxt     = DONE;
      psum_nxt      = (io.relu_en && mac_out[psum_bw-1]) ? '0 : mac_out;
      out_valid_nxt = 1'b1;
      acc_nxt       = '0;
      cnt_nxt       = '0;
    end
  end

endmodule

// File: tb/tb_mac_psum_accum.sv
// Bench for mac_psum_accum: behavioural 4-lane mac in the loop, expected results
// queued at stimulus time and compared as each result leaves the block.
module tb_mac_psum_accum;
  import mac_psum_accum_pkg::*;

  logic                clk;
  logic                reset;
  logic [LANES*BW-1:0] mac_a;
  logic [LANES*BW-1:0] mac_b;
  psum_t               mac_c;
  psum_t               mac_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] sb[$];

  mac_psum_accum_if io ();

  mac_psum_accum dut (
    .clk     (clk),
    .reset   (reset),
    .io      (io),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_c   (mac_c),
    .mac_out (mac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden mac: out = c + sum(unsigned a_i * signed b_i), truncated.
  always_comb begin
    int s;
    s = int'(mac_c);
    for (int i = 0; i < 4; i++)
      s = s + int'(mac_a[i*4 +: 4]) * int'($signed(mac_b[i*4 +: 4]));
    mac_out = psum_t'(16'(s));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result monitor plus the ready/valid exclusivity invariant.
  always @(negedge clk) begin
    if (!reset) begin
      check("rdy_vs_vld", 32'(io.in_ready), 32'(!io.out_valid));
      if (io.out_valid && io.out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 32'(1), 32'(0));
        else                check("psum", {16'b0, io.psum_out}, {16'b0, sb.pop_front()});
      end
    end
  end

  task automatic send_group(input int k, input logic [3:0] a, input logic [3:0] b,
                            input logic relu, input bit bubbles);
    int ke;
    int s;
    int guard;
    logic [15:0] e;
    ke = (k == 0) ? 1 : k;
    s  = 0;
    for (int i = 0; i < ke; i++) s = s + 4 * int'(a) * int'($signed(b));
    e = 16'(s);
    if (relu && e[15]) e = 16'h0000;
    sb.push_back(e);
    for (int i = 0; i < ke; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.a_in     = {4{a}};
      io.b_in     = {4{b}};
      io.k_groups = (i == 0) ? 8'(k) : 8'($urandom);
      io.relu_en  = (i == ke - 1) ? relu : !relu;
      guard = 0;
      while (!io.in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) check("in_ready_timeout", 32'(0), 32'(1));
      @(posedge clk);
      if (bubbles && i < 2 && i != ke - 1) begin
        @(negedge clk);
        io.in_valid = 1'b0;
        @(posedge clk);
      end
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    check("latency", 32'(io.out_valid), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.a_in      = '0;
    io.b_in      = '0;
    io.k_groups  = '0;
    io.relu_en   = 1'b0;
    io.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(io.out_valid), 32'(0));
    check("rst_psum",      {16'b0, io.psum_out}, 32'(0));
    check("rst_acc",       {16'b0, mac_c}, 32'(0));
    check("rst_in_ready",  32'(io.in_ready), 32'(1));
    reset = 1'b0;

    send_group(3, 4'h1, 4'h2, 1'b0, 1'b0);   // 24
    send_group(2, 4'h3, 4'hF, 1'b0, 1'b0);   // -24
    send_group(2, 4'h3, 4'hF, 1'b1, 1'b0);   // ReLU -> 0

    // Backpressure with input bubbles
    @(posedge clk);
    #1 io.out_ready = 1'b0;
    send_group(4, 4'h1, 4'h1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", 32'(io.out_valid), 32'(1));
      check("bp_ready", 32'(io.in_ready), 32'(0));
      check("bp_psum",  {16'b0, io.psum_out}, 32'd16);
    end
    @(posedge clk);
    #1 io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", 32'(io.out_valid), 32'(0));

    send_group(0, 4'h2, 4'h3, 1'b0, 1'b0);   // k=0 acts as 1 -> 24
    send_group(1, 4'h2, 4'h3, 1'b0, 1'b0);   // again 24, acc cleared
    send_group(160, 4'hF, 4'h7, 1'b0, 1'b0); // wraps to 0x0680

    // Reset after two beats of a k=4 group discards it
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.a_in     = {4{4'h1}};
      io.b_in     = {4{4'h1}};
      io.k_groups = 8'd4;
      io.relu_en  = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", 32'(io.out_valid), 32'(0));
    check("mid_rst_acc",   {16'b0, mac_c}, 32'(0));
    check("mid_rst_psum",  {16'b0, io.psum_out}, 32'(0));
    check("mid_rst_ready", 32'(io.in_ready), 32'(1));
    send_group(1, 4'h1, 4'h1, 1'b0, 1'b0);   // 4

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drain", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
